// File: rtl/md5_result_arbiter.sv
// Round-robin collector of cracker-core results: drives the one-hot selector,
// captures its registered output and streams each word out with a per-core ack.
module md5_result_arbiter #(
    parameter int SETTLE = 1
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [5:0]  found,
    output logic        select0,
    output logic        select1,
    output logic        select2,
    output logic        select3,
    output logic        select4,
    output logic        select5,
    input  logic [31:0] data_in,
    output logic [31:0] word_out,
    output logic [2:0]  src_id,
    output logic        word_valid,
    input  logic        word_ready,
    output logic [5:0]  ack,
    output logic        sel_err
);
    localparam int          CW       = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    localparam logic [31:0] ERR_WORD = 32'hFEFEFEFE;

    typedef enum logic [1:0] {IDLE, WAIT, PRESENT} state_t;

    state_t        state_reg, state_next;
    logic [5:0]    found_d_reg;
    logic [5:0]    pending_reg, pending_next;
    logic [2:0]    ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [31:0]   word_next;
    logic [2:0]    src_next;
    logic          valid_next;
    logic [5:0]    ack_next;
    logic          err_next;
    logic [5:0]    rise;
    logic [5:0]    clr_vec;
    logic [5:0]    sel_vec;
    logic          grant_ok;
    logic [2:0]    grant_idx;
    logic [3:0]    scan_sum;

    // A rise in the same cycle as the clear wins, so a re-raised request is kept.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_core
            assign rise[gi]         = found[gi] & ~found_d_reg[gi];
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr_vec[gi]);
        end
    endgenerate

    // First pending core at or after ptr, wrapping 5 -> 0.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = 3'd0;
        scan_sum  = 4'd0;
        for (int k = 0; k < 6; k++) begin
            scan_sum = {1'b0, ptr_reg} + 4'(k);
            if (scan_sum >= 4'd6) begin
                scan_sum = scan_sum - 4'd6;
            end
            if (!grant_ok && pending_reg[scan_sum[2:0]]) begin
                grant_ok  = 1'b1;
                grant_idx = scan_sum[2:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_ok)        state_next = WAIT;
            WAIT:    if (cnt_reg == '0)   state_next = PRESENT;
            PRESENT: if (word_ready)      state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next   = cnt_reg;
        word_next  = word_out;
        src_next   = src_id;
        valid_next = word_valid;
        ack_next   = 6'd0;
        err_next   = sel_err;
        ptr_next   = ptr_reg;
        clr_vec    = 6'd0;
        sel_vec    = 6'd0;
        case (state_reg)
            IDLE: begin
                if (grant_ok) begin
                    src_next = grant_idx;
                    cnt_next = CW'(SETTLE);
                end
            end
            WAIT: begin
                sel_vec[src_id] = 1'b1;
                if (cnt_reg == '0) begin
                    word_next  = data_in;
                    valid_next = 1'b1;
                    if (data_in == ERR_WORD) begin
                        err_next = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            PRESENT: begin
                if (word_ready) begin
                    valid_next       = 1'b0;
                    ack_next[src_id] = 1'b1;
                    clr_vec[src_id]  = 1'b1;
                    ptr_next         = (src_id == 3'd5) ? 3'd0 : src_id + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            found_d_reg <= 6'd0;
            pending_reg <= 6'd0;
            ptr_reg     <= 3'd0;
            cnt_reg     <= '0;
            word_out    <= 32'd0;
            src_id      <= 3'd0;
            word_valid  <= 1'b0;
            ack         <= 6'd0;
            sel_err     <= 1'b0;
        end else begin
            found_d_reg <= found;
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            word_out    <= word_next;
            src_id      <= src_next;
            word_valid  <= valid_next;
            ack         <= ack_next;
            sel_err     <= err_next;
        end
    end

    assign select0 = sel_vec[0];
    assign select1 = sel_vec[1];
    assign select2 = sel_vec[2];
    assign select3 = sel_vec[3];
    assign select4 = sel_vec[4];
    assign select5 = sel_vec[5];

endmodule
